// File: rtl/fpga_link_arbiter.sv
// Round-robin TX arbiter and one-entry RX holding register for a single fpga_protocol link.
// Grant and link_start follow an idle-cycle request by one clock; RX holds the byte until rx_ready, then acks the link.
module fpga_link_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int START_CYCLES = 2,
  parameter int PROC_CYCLES  = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          tx_err,
  output logic [DATA_WIDTH-1:0]         link_data_in,
  output logic                          link_start,
  input  logic                          link_busy,
  input  logic [DATA_WIDTH-1:0]         link_data_out,
  input  logic                          link_received,
  output logic                          link_processed,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);
  localparam logic [7:0]    START_LAST = 8'(START_CYCLES - 1);
  localparam logic [7:0]    PROC_LAST  = 8'(PROC_CYCLES - 1);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_HI, T_WAIT_LO} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_ACK, R_WAIT_LO} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [7:0]            tx_cnt, tx_cnt_next;
  logic [7:0]            rx_cnt, rx_cnt_next;
  logic [IW-1:0]         cur, cur_next;
  logic [IW-1:0]         rr_ptr, rr_next, ptr_after;
  logic [IW-1:0]         pick;
  logic                  found;
  int                    arb_idx;
  logic [DATA_WIDTH-1:0] data_next, rx_data_next;
  logic [NUM_REQ-1:0]    done_next;
  logic                  err_next;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    pick    = rr_ptr;
    arb_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!found && req[IW'(arb_idx)]) begin
        found = 1'b1;
        pick  = IW'(arb_idx);
      end
    end
  end

  assign ptr_after = (cur == LAST_REQ) ? '0 : cur + 1'b1;

  always_comb begin
    tx_next     = tx_state;
    tx_cnt_next = tx_cnt;
    cur_next    = cur;
    rr_next     = rr_ptr;
    data_next   = link_data_in;
    done_next   = '0;
    err_next    = 1'b0;
    grant       = '0;
    link_start  = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (found) begin
          cur_next    = pick;
          data_next   = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
          tx_cnt_next = '0;
          tx_next     = T_START;
        end
      end
      T_START: begin
        link_start = 1'b1;
        if (tx_cnt == '0) grant[cur] = 1'b1;
        if (tx_cnt == START_LAST) begin
          tx_cnt_next = '0;
          tx_next     = T_WAIT_HI;
        end else begin
          tx_cnt_next = tx_cnt + 8'd1;
        end
      end
      T_WAIT_HI: begin
        // tx_err lands TIMEOUT cycles after entry, i.e. after TIMEOUT low samples of busy.
        if (link_busy) begin
          tx_next = T_WAIT_LO;
        end else if (tx_cnt == TO_LAST) begin
          err_next = 1'b1;
          rr_next  = ptr_after;
          tx_next  = T_IDLE;
        end else begin
          tx_cnt_next = tx_cnt + 8'd1;
        end
      end
      T_WAIT_LO: begin
        if (!link_busy) begin
          done_next[cur] = 1'b1;
          rr_next        = ptr_after;
          tx_next        = T_IDLE;
        end
      end
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    rx_next        = rx_state;
    rx_cnt_next    = rx_cnt;
    rx_data_next   = rx_data;
    rx_valid       = 1'b0;
    link_processed = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (link_received) begin
          rx_data_next = link_data_out;
          rx_next      = R_HOLD;
        end
      end
      R_HOLD: begin
        rx_valid = 1'b1;
        if (rx_ready) begin
          rx_cnt_next = '0;
          rx_next     = R_ACK;
        end
      end
      R_ACK: begin
        link_processed = 1'b1;
        if (rx_cnt == PROC_LAST) rx_next = R_WAIT_LO;
        else rx_cnt_next = rx_cnt + 8'd1;
      end
      R_WAIT_LO: begin
        // Received must drop before another capture, so one pulse yields one byte.
        if (!link_received) rx_next = R_IDLE;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state     <= T_IDLE;
      rx_state     <= R_IDLE;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      cur          <= '0;
      rr_ptr       <= '0;
      link_data_in <= '0;
      rx_data      <= '0;
      done         <= '0;
      tx_err       <= 1'b0;
    end else begin
      tx_state     <= tx_next;
      rx_state     <= rx_next;
      tx_cnt       <= tx_cnt_next;
      rx_cnt       <= rx_cnt_next;
      cur          <= cur_next;
      rr_ptr       <= rr_next;
      link_data_in <= data_next;
      rx_data      <= rx_data_next;
      done         <= done_next;
      tx_err       <= err_next;
    end
  end

endmodule

// File: tb/tb_fpga_link_arbiter.sv
// Directed-plus-random bench for fpga_link_arbiter; the bench plays the fpga_protocol side of the link.
module tb_fpga_link_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int PC = 2;
  localparam int TO = 255;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            tx_err;
  logic [DW-1:0]   link_data_in;
  logic            link_start;
  logic            link_busy;
  logic [DW-1:0]   link_data_out;
  logic            link_received;
  logic            link_processed;
  logic [DW-1:0]   rx_data;
  logic            rx_valid;
  logic            rx_ready;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  fpga_link_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .START_CYCLES(SC), .PROC_CYCLES(PC), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .tx_err(tx_err),
    .link_data_in(link_data_in), .link_start(link_start), .link_busy(link_busy),
    .link_data_out(link_data_out), .link_received(link_received),
    .link_processed(link_processed), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic tx_begin(input logic [3:0] r, input logic [31:0] d, output int w);
    req      = r;
    req_data = d;
    w        = rr_pick(r, m_ptr);
    @(negedge clock);
    chk("grant", grant, 1 << w);
    chk("start_first", link_start, 1);
    chk("data_in", link_data_in, d[w*8 +: 8]);
    chk("done_quiet", done, 0);
    req = '0;
    for (int c = 1; c < SC; c++) begin
      @(negedge clock);
      chk("start_hold", link_start, 1);
      chk("grant_once", grant, 0);
    end
    @(negedge clock);
    chk("start_end", link_start, 0);
  endtask

  task automatic do_tx(input logic [3:0] r, input logic [31:0] d, input int dly, input int len);
    int w;
    tx_begin(r, d, w);
    repeat (dly) @(negedge clock);
    link_busy = 1'b1;
    repeat (len) @(negedge clock);
    chk("done_busy", done, 0);
    link_busy = 1'b0;
    @(negedge clock);
    chk("done", done, 1 << w);
    chk("err_none", tx_err, 0);
    m_ptr = (w + 1) % N;
    @(negedge clock);
    chk("done_pulse", done, 0);
  endtask

  task automatic do_tx_timeout(input logic [3:0] r, input logic [31:0] d);
    int w;
    tx_begin(r, d, w);
    repeat (TO - 1) @(negedge clock);
    chk("err_early", tx_err, 0);
    @(negedge clock);
    chk("tx_err", tx_err, 1);
    chk("done_on_err", done, 0);
    m_ptr = (w + 1) % N;
    @(negedge clock);
    chk("err_pulse", tx_err, 0);
  endtask

  task automatic do_rx(input logic [7:0] d, input int rdy_dly, input int extra);
    link_received = 1'b1;
    link_data_out = d;
    @(negedge clock);
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, d);
    chk("proc_idle", link_processed, 0);
    link_data_out = ~d;
    repeat (rdy_dly) begin
      @(negedge clock);
      chk("rx_hold_valid", rx_valid, 1);
      chk("rx_hold_data", rx_data, d);
      chk("proc_early", link_processed, 0);
    end
    rx_ready = 1'b1;
    @(negedge clock);
    chk("rx_taken", rx_valid, 0);
    chk("proc_first", link_processed, 1);
    rx_ready = 1'b0;
    for (int c = 1; c < PC; c++) begin
      @(negedge clock);
      chk("proc_hold", link_processed, 1);
    end
    @(negedge clock);
    chk("proc_len", link_processed, 0);
    repeat (extra) begin
      @(negedge clock);
      chk("no_recapture", rx_valid, 0);
    end
    link_received = 1'b0;
    @(negedge clock);
    chk("rx_idle", rx_valid, 0);
  endtask

  initial begin
    int w;
    reset         = 1'b0;
    req           = '0;
    req_data      = '0;
    link_busy     = 1'b0;
    link_data_out = '0;
    link_received = 1'b0;
    rx_ready      = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_start", link_start, 0);
    chk("rst_data_in", link_data_in, 0);
    chk("rst_proc", link_processed, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b1;
    @(negedge clock);

    // Round robin with every requester asking: expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      do_tx(4'b1111, 32'h13121110, $urandom_range(0, 4), $urandom_range(1, 3));

    do_tx(4'b0100, 32'h002D0000, 0, 1);

    // Busy never rises; pointer must still advance past the timed-out requester.
    do_tx_timeout(4'b0001, $urandom);
    do_tx(4'b0011, $urandom, 1, 1);
    do_tx(4'b0001, $urandom, 0, 2);

    do_rx(8'hA5, 20, 3);

    // TX and RX overlapping.
    w             = rr_pick(4'b0010, m_ptr);
    req           = 4'b0010;
    req_data      = 32'h00003C00;
    link_received = 1'b1;
    link_data_out = 8'h5A;
    @(negedge clock);
    chk("cc_grant", grant, 1 << w);
    chk("cc_data_in", link_data_in, 8'h3C);
    chk("cc_rx_valid", rx_valid, 1);
    chk("cc_rx_data", rx_data, 8'h5A);
    req      = '0;
    rx_ready = 1'b1;
    @(negedge clock);
    chk("cc_start", link_start, 1);
    chk("cc_rx_taken", rx_valid, 0);
    chk("cc_proc1", link_processed, 1);
    rx_ready  = 1'b0;
    @(negedge clock);
    chk("cc_start_end", link_start, 0);
    chk("cc_proc2", link_processed, 1);
    link_busy = 1'b1;
    @(negedge clock);
    chk("cc_proc_end", link_processed, 0);
    link_busy     = 1'b0;
    link_received = 1'b0;
    @(negedge clock);
    chk("cc_done", done, 1 << w);
    chk("cc_rx_idle", rx_valid, 0);
    m_ptr = (w + 1) % N;
    @(negedge clock);
    chk("cc_done_pulse", done, 0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_tx(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 6), $urandom_range(1, 4));
      else
        do_rx(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // Reset in the middle of a TX busy phase and an RX hold; the stale pointer would favour 3.
    do_tx(4'b0100, $urandom, 0, 1);
    req           = 4'b1000;
    req_data      = $urandom;
    link_received = 1'b1;
    link_data_out = 8'hC3;
    @(negedge clock);
    chk("mr_grant", grant, 4'b1000);
    req = 4'b1010;
    repeat (SC) @(negedge clock);
    link_busy = 1'b1;
    @(negedge clock);
    chk("mr_rx_hold", rx_valid, 1);
    reset = 1'b0;
    #1;
    chk("mr_outputs", {grant, done, tx_err, link_start, link_processed, rx_valid, rx_data, link_data_in}, 0);
    link_busy     = 1'b0;
    link_received = 1'b0;
    m_ptr         = 0;
    repeat (2) @(negedge clock);
    chk("mr_no_done", done, 0);
    chk("mr_no_err", tx_err, 0);
    reset = 1'b1;
    do_tx(4'b1010, $urandom, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpga_link_arbiter.md
Name: fpga_link_arbiter

Overview:
Shares one fpga_protocol link between NUM_REQ local requesters and sequences its start/busy and received/processed handshakes. TX side: round-robin arbitration, data latch, start pulse generation, busy tracking with timeout. RX side: captures link_data_out into a one-entry holding register, presents it on a valid/ready port, then acknowledges the link with a processed pulse. Sits between client logic and the fpga_protocol instance.

Parameters:
NUM_REQ, 4, number of TX requesters (2..8)
DATA_WIDTH, 8, link data width
START_CYCLES, 2, clock cycles link_start is held high
PROC_CYCLES, 2, clock cycles link_processed is held high
TIMEOUT, 255, max cycles to wait for link_busy rise after start (8-bit counter)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester transmit request (level)
req_data  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  NUM_REQ  one-cycle pulse: requester's data latched
done  out  NUM_REQ  one-cycle pulse: granted transfer completed (busy fell)
tx_err  out  1  one-cycle pulse: busy-rise timeout
link_data_in  out  DATA_WIDTH  to fpga_protocol data_in
link_start  out  1  to fpga_protocol start
link_busy  in  1  from fpga_protocol busy
link_data_out  in  DATA_WIDTH  from fpga_protocol data_out
link_received  in  1  from fpga_protocol received
link_processed  out  1  to fpga_protocol processed
rx_data  out  DATA_WIDTH  captured receive byte
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data

Behaviour:
- reset low (async): all outputs 0, link_data_in 0, rr_ptr 0, both FSMs idle, counters 0; takes effect immediately, including mid-transfer; no done/err emitted for aborted transfer.
- TX FSM states: T_IDLE, T_START, T_WAIT_HI, T_WAIT_LO.
- T_IDLE: if any req set, winner w = first set index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Same edge: link_data_in <= req_data[w], grant[w]=1 next cycle (single bit), go T_START. req sampled only in T_IDLE; requester holds req/data stable until grant, deasserts after grant or is re-arbitrated.
- T_START: link_start=1 for exactly START_CYCLES cycles, then T_WAIT_HI with timeout counter cleared.
- T_WAIT_HI: on link_busy=1 -> T_WAIT_LO. If counter reaches TIMEOUT with busy still 0: tx_err pulse, rr_ptr <= w+1, -> T_IDLE, no done.
- T_WAIT_LO: on link_busy=0 -> done[w] pulse 1 cycle, rr_ptr <= (w+1) mod NUM_REQ, -> T_IDLE. No busy timeout here.
- link_data_in holds last latched value until next grant.
- Latency: req at T_IDLE edge -> grant next cycle, link_start high same cycle as grant for START_CYCLES cycles. Minimum idle gap between transfers: 1 cycle (T_IDLE).
- RX FSM states: R_IDLE, R_HOLD, R_ACK, R_WAIT_LO.
- R_IDLE: on link_received=1 -> rx_data <= link_data_out, rx_valid=1, -> R_HOLD.
- R_HOLD: rx_valid stays 1, rx_data stable; on rx_ready=1 (handshake cycle) rx_valid clears next edge, -> R_ACK. rx_ready while rx_valid=0 ignored.
- R_ACK: link_processed=1 for PROC_CYCLES cycles, -> R_WAIT_LO.
- R_WAIT_LO: wait link_received=0, -> R_IDLE. Ensures one capture per received pulse.
- TX and RX FSMs independent; simultaneous activity allowed, no interaction.

Test Plan:
- Single: req[2]=1, data 45 -> grant=4'b0100 one cycle, link_data_in=45, link_start high 2 cycles, busy 1 then 0 -> done=4'b0100 one cycle.
- Round-robin: req=4'b1111 held, data 10,11,12,13 -> grants in order 0,1,2,3,0; each done precedes next grant.
- Timeout: req[0]=1, busy held 0 -> tx_err pulse 255 cycles after T_WAIT_HI entry, no done, rr_ptr=1, req[0] re-granted next.
- RX backpressure: link_received=1 with data_out=8'hA5, rx_ready=0 for 20 cycles -> rx_valid=1, rx_data=A5 stable, link_processed 0; rx_ready=1 -> rx_valid 0, link_processed high 2 cycles, no second capture while received remains high.
- Reset mid-transfer: reset low during T_WAIT_LO and R_HOLD -> all outputs 0 immediately; after release, pending req[1] granted first (rr_ptr 0 search), no stale done.
- Concurrent: TX transfer of 8'h3C while RX captures 8'h5A -> both complete with correct values, handshakes unchanged.
